// File: rtl/instr_loader.sv
// Byte-stream program loader: packs four bytes MSB-first into 32-bit words and
// issues one write per word to the instruction memory until last byte or capacity.
module instr_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_last_i,
    output logic             byte_ready_o,
    output logic             wr_en_o,
    output logic [31:0]      wr_addr_o,
    output logic [31:0]      wr_data_o,
    output logic [CNT_W-1:0] word_count_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  byte_cnt_q;
    logic [31:0] shift_q;
    logic [31:0] packed_word;
    logic        accept;
    logic        word_end;
    logic        final_word;
    logic        restart;

    // Drops byte k into its MSB-first lane; untouched lanes stay zero, which
    // gives the zero padding of a short final word for free.
    function automatic logic [31:0] place_byte(input logic [31:0] acc,
                                               input logic [7:0]  b,
                                               input logic [1:0]  k);
        logic [31:0] r;
        r = acc;
        case (k)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    assign accept      = (state_q == LOAD) && byte_valid_i;
    assign word_end    = accept && ((byte_cnt_q == 2'd3) || byte_last_i);
    assign final_word  = word_end && (byte_last_i || (word_count_o == CNT_W'(DEPTH - 1)));
    assign restart     = (state_q != LOAD) && start_i;
    assign packed_word = place_byte(shift_q, byte_i, byte_cnt_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (final_word) state_d = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Packing datapath and registered write port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_cnt_q   <= 2'd0;
            shift_q      <= 32'd0;
            word_count_o <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= 32'd0;
            wr_data_o    <= 32'd0;
        end else begin
            wr_en_o <= 1'b0;
            if (restart) begin
                byte_cnt_q   <= 2'd0;
                shift_q      <= 32'd0;
                word_count_o <= '0;
            end else if (word_end) begin
                wr_en_o      <= 1'b1;
                wr_data_o    <= packed_word;
                wr_addr_o    <= {{(30 - CNT_W){1'b0}}, word_count_o, 2'b00};
                word_count_o <= word_count_o + 1'b1;
                byte_cnt_q   <= 2'd0;
                shift_q      <= 32'd0;
            end else if (accept) begin
                shift_q    <= packed_word;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: logs every write strobe and compares against
// hand-computed addresses/data for full, partial, capacity, backpressure and reset cases.
module tb_instr_loader;

    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic             byte_valid_i;
    logic [7:0]       byte_i;
    logic             byte_last_i;
    logic             byte_ready_o;
    logic             wr_en_o;
    logic [31:0]      wr_addr_o;
    logic [31:0]      wr_data_o;
    logic [CNT_W-1:0] word_count_o;
    logic             busy_o;
    logic             done_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] log_addr [256];
    logic [31:0] log_data [256];
    logic        log_done [256];
    int          wtotal  = 0;
    int          consec  = 0;
    bit          prev_wr = 1'b0;

    instr_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_last_i  (byte_last_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .word_count_o (word_count_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en_o === 1'b1) begin
            if (wtotal < 256) begin
                log_addr[wtotal] = wr_addr_o;
                log_data[wtotal] = wr_data_o;
                log_done[wtotal] = done_o;
            end
            wtotal = wtotal + 1;
            if (prev_wr) consec = consec + 1;
        end
        prev_wr = (wr_en_o === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data);
        check({tag, "_addr"}, (idx < 256) ? log_addr[idx] : 32'hDEAD_BEEF, addr);
        check({tag, "_data"}, (idx < 256) ? log_data[idx] : 32'hDEAD_BEEF, data);
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        start_i      = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input logic st);
        byte_valid_i = 1'b1;
        byte_i       = b;
        byte_last_i  = last;
        start_i      = st;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    // Gap cycle before each byte carries a bogus last flag with valid low.
    task automatic send_bp(input logic [7:0] b, input logic last);
        byte_valid_i = 1'b0;
        byte_i       = 8'hEE;
        byte_last_i  = 1'b1;
        @(negedge clk);
        send(b, last, 1'b0);
    endtask

    logic [7:0] two_word [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] part_word [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

    initial begin
        int base;
        logic [7:0] b0;
        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00; byte_last_i = 1'b0;

        // Reset with random inputs for two edges
        repeat (2) begin
            @(negedge clk);
            start_i      = 1'($urandom);
            byte_valid_i = 1'($urandom);
            byte_i       = 8'($urandom);
            byte_last_i  = 1'($urandom);
        end
        @(negedge clk);
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_addr", wr_addr_o, 32'd0);
        check("rst_data", wr_data_o, 32'd0);
        check("rst_count", 32'(word_count_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        idle(2);
        check("idle_no_wr", 32'(wtotal), 32'd0);

        // Two-word load at full rate
        base = wtotal;
        do_start();
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_ready", 32'(byte_ready_o), 32'd1);
        for (int i = 0; i < 8; i++) send(two_word[i], (i == 7), 1'b0);
        check("tw_final_wr_en", 32'(wr_en_o), 32'd1);
        check("tw_final_done", 32'(done_o), 32'd1);
        check("tw_final_busy", 32'(busy_o), 32'd0);
        check("tw_final_ready", 32'(byte_ready_o), 32'd0);
        idle(1);
        check("tw_wr_en_low", 32'(wr_en_o), 32'd0);
        idle(2);
        check("tw_nwr", 32'(wtotal - base), 32'd2);
        check_wr("tw_w0", base, 32'h0, 32'h2008_0005);
        check_wr("tw_w1", base + 1, 32'h4, 32'h0000_0000);
        check("tw_w0_not_done", 32'(log_done[base]), 32'd0);
        check("tw_count", 32'(word_count_o), 32'd2);

        // Partial final word, then bytes that must not be accepted
        base = wtotal;
        do_start();
        check("restart_count", 32'(word_count_o), 32'd0);
        for (int i = 0; i < 6; i++) send(part_word[i], (i == 5), 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        idle(3);
        check("pw_nwr", 32'(wtotal - base), 32'd2);
        check_wr("pw_w0", base, 32'h0, 32'hAABB_CCDD);
        check_wr("pw_w1", base + 1, 32'h4, 32'h1122_0000);
        check("pw_count", 32'(word_count_o), 32'd2);
        check("pw_hold_data", wr_data_o, 32'h1122_0000);
        check("pw_hold_addr", wr_addr_o, 32'h4);

        // Capacity: 128 bytes then four more offered
        base = wtotal;
        do_start();
        for (int i = 0; i < 4 * DEPTH; i++) send(8'(i), 1'b0, 1'b0);
        check("cap_final_done", 32'(done_o), 32'd1);
        for (int i = 0; i < 4; i++) send(8'hF0 + 8'(i), 1'b0, 1'b0);
        idle(3);
        check("cap_nwr", 32'(wtotal - base), 32'(DEPTH));
        for (int w = 0; w < DEPTH; w++) begin
            b0 = 8'(4 * w);
            check_wr($sformatf("cap_w%0d", w), base + w, 32'(4 * w),
                     {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
        end
        check("cap_last_done", 32'(log_done[base + DEPTH - 1]), 32'd1);
        check("cap_ready", 32'(byte_ready_o), 32'd0);
        check("cap_count", 32'(word_count_o), 32'(DEPTH));

        // Backpressure: valid every other cycle, bogus last in the gaps
        base = wtotal;
        do_start();
        for (int i = 0; i < 8; i++) send_bp(two_word[i], (i == 7));
        idle(3);
        check("bp_nwr", 32'(wtotal - base), 32'd2);
        check_wr("bp_w0", base, 32'h0, 32'h2008_0005);
        check_wr("bp_w1", base + 1, 32'h4, 32'h0000_0000);
        check("bp_count", 32'(word_count_o), 32'd2);

        // Restart from DONE, then mid-word reset
        base = wtotal;
        do_start();
        check("rs_count0", 32'(word_count_o), 32'd0);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b1);
        for (int i = 6; i <= 12; i++) send(8'(i), 1'b0, 1'b0);
        check("rs_count3", 32'(word_count_o), 32'd3);
        send(8'h0D, 1'b0, 1'b0);
        send(8'h0E, 1'b0, 1'b0);
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("mr_count", 32'(word_count_o), 32'd0);
        check("mr_busy", 32'(busy_o), 32'd0);
        check("mr_done", 32'(done_o), 32'd0);
        check("mr_ready", 32'(byte_ready_o), 32'd0);
        idle(3);
        check("mr_nwr", 32'(wtotal - base), 32'd3);
        check_wr("rs_w0", base, 32'h0, 32'h0102_0304);
        check_wr("rs_w1", base + 1, 32'h4, 32'h0506_0708);
        check_wr("rs_w2", base + 2, 32'h8, 32'h090A_0B0C);
        base = wtotal;
        do_start();
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        send(8'hA3, 1'b0, 1'b0);
        send(8'hA4, 1'b1, 1'b0);
        idle(3);
        check("mr_next_nwr", 32'(wtotal - base), 32'd1);
        check_wr("mr_next", base, 32'h0, 32'hA1A2_A3A4);
        check("mr_next_done", 32'(done_o), 32'd1);
        check("no_back_to_back", 32'(consec), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
